// File: rtl/spi_cmd_blink.sv
// spi_cmd_blink: parses 2-byte SPI commands (opcode, argument) into LED mode / blink-period registers.
// Optional macro SPI_CMD_TIMEOUT_EN: abandons a command whose argument byte fails to arrive in time.
module spi_cmd_blink #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned TICK_HZ       = 1000,
  parameter logic [7:0]  DEFAULT_HALF  = 8'd250,
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_s_cs_n,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_data,
  output logic       o_led,
  output logic [1:0] o_mode,
  output logic [7:0] o_half,
  output logic       o_cmd_valid,
  output logic       o_cmd_err
);

  localparam int unsigned PRE_CNT = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;

  localparam logic [7:0] OP_MODE   = 8'h10;
  localparam logic [7:0] OP_HALF   = 8'h20;
  localparam logic [7:0] OP_CLRERR = 8'h30;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BAD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             done_q;
  logic             strobe_c;
  logic [7:0]       opcode_q;
  logic [7:0]       arg_q;
  logic [PRE_W-1:0] pre_q;
  logic             tick_c;
  logic [7:0]       half_cnt_q;
  logic             timeout_c;

  logic ld_op_c;
  logic ld_arg_c;
  logic exec_c;
  logic abort_c;
  logic mode_wr_c;
  logic half_wr_c;
  logic err_set_c;
  logic err_clr_c;

  // Rising edge of the upstream done flag is the only byte event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) done_q <= 1'b0;
    else          done_q <= i_rx_done;
  end

  assign strobe_c = i_rx_done & ~done_q;

  // Free-running time-base prescaler.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            pre_q <= '0;
    else if (pre_q == PRE_W'(PRE_CNT - 1))   pre_q <= '0;
    else                                     pre_q <= pre_q + PRE_W'(1);
  end

  assign tick_c = (pre_q == PRE_W'(PRE_CNT - 1));

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 2);
  logic [TO_W-1:0] to_cnt_q;

  // Counts ticks spent waiting for the argument byte; zero outside ARG.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              to_cnt_q <= '0;
    else if (state_q != S_ARG) to_cnt_q <= '0;
    else if (tick_c)           to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timeout_c = (state_q == S_ARG) && (to_cnt_q == TO_W'(TIMEOUT_TICKS));
`else
  // ARG waits for its byte indefinitely.
  assign timeout_c = 1'b0 && (TIMEOUT_TICKS != 0);
`endif

  // Parser state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state: a high chip select resynchronises the parser.
  always_comb begin
    state_d = state_q;
    if (i_spi_s_cs_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (strobe_c) state_d = S_ARG;
        S_ARG: begin
          if (strobe_c)       state_d = S_EXEC;
          else if (timeout_c) state_d = S_IDLE;
        end
        S_EXEC:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Parser control outputs.
  always_comb begin
    ld_op_c  = 1'b0;
    ld_arg_c = 1'b0;
    abort_c  = 1'b0;
    exec_c   = (state_q == S_EXEC);
    if (!i_spi_s_cs_n) begin
      case (state_q)
        S_IDLE:  ld_op_c = strobe_c;
        S_ARG: begin
          ld_arg_c = strobe_c;
          abort_c  = ~strobe_c & timeout_c;
        end
        default: ;
      endcase
    end
  end

  // Command decode during the execute cycle.
  always_comb begin
    mode_wr_c = 1'b0;
    half_wr_c = 1'b0;
    err_set_c = abort_c;
    err_clr_c = 1'b0;
    if (exec_c) begin
      case (opcode_q)
        OP_MODE: begin
          if (arg_q[1:0] == MODE_BAD) err_set_c = 1'b1;
          else                        mode_wr_c = 1'b1;
        end
        OP_HALF:   half_wr_c = 1'b1;
        OP_CLRERR: err_clr_c = 1'b1;
        default:   err_set_c = 1'b1;
      endcase
    end
  end

  // Command bytes and architectural registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opcode_q    <= '0;
      arg_q       <= '0;
      o_mode      <= MODE_BLINK;
      o_half      <= DEFAULT_HALF;
      o_cmd_valid <= 1'b0;
      o_cmd_err   <= 1'b0;
    end else begin
      o_cmd_valid <= exec_c;
      if (ld_op_c)   opcode_q <= i_rx_data;
      if (ld_arg_c)  arg_q    <= i_rx_data;
      if (mode_wr_c) o_mode   <= arg_q[1:0];
      if (half_wr_c) o_half   <= (arg_q == 8'd0) ? 8'd1 : arg_q;
      if (err_set_c)      o_cmd_err <= 1'b1;
      else if (err_clr_c) o_cmd_err <= 1'b0;
    end
  end

  // LED drive: steady in off/on, toggles every o_half ticks in blink.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_led      <= 1'b0;
      half_cnt_q <= '0;
    end else if (mode_wr_c) begin
      half_cnt_q <= '0;
      o_led      <= (arg_q[1:0] != MODE_OFF);
    end else if (o_mode != MODE_BLINK) begin
      half_cnt_q <= '0;
      o_led      <= (o_mode == MODE_ON);
    end else if (half_wr_c) begin
      half_cnt_q <= '0;
    end else if (tick_c) begin
      if (half_cnt_q >= o_half - 8'd1) begin
        half_cnt_q <= '0;
        o_led      <= ~o_led;
      end else begin
        half_cnt_q <= half_cnt_q + 8'd1;
      end
    end
  end

endmodule
